// File: rtl/fft_pkg.sv
// Shared types and default constants for the FFT butterfly stage.
// Optional macro FFT_STAGE_ERR_EN is consumed by fft_frame_cnt and fft_bfly_stage.
package fft_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } stage_state_t;

    localparam int FFT_WIDTH        = 16;
    localparam int FFT_LANES        = 16;
    localparam int FFT_FRAME_CYCLES = 32;

endpackage

// File: rtl/fft_frame_cnt.sv
// Frame sequencer: IDLE/RUN FSM, beat counter, active window and frame_done.
// Macro FFT_STAGE_ERR_EN adds a sticky err flag for starts ignored mid-frame.
module fft_frame_cnt
    import fft_pkg::*;
#(
    parameter int FRAME_CYCLES = FFT_FRAME_CYCLES
) (
    input  logic clk,
    input  logic rstn,
    input  logic start,
    output logic active,
    output logic frame_done
`ifdef FFT_STAGE_ERR_EN
    ,
    output logic err
`endif
);

    localparam int CW = (FRAME_CYCLES > 1) ? $clog2(FRAME_CYCLES) : 1;
    localparam logic [CW-1:0] LAST = CW'(FRAME_CYCLES - 1);

    stage_state_t state, state_nxt;
    logic [CW-1:0] cnt, cnt_nxt;
    logic last;

    assign last   = (cnt == LAST);
    assign active = (state == RUN);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state      <= IDLE;
            cnt        <= '0;
            frame_done <= 1'b0;
        end else begin
            state      <= state_nxt;
            cnt        <= cnt_nxt;
            frame_done <= active && last;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        unique case (state)
            IDLE: begin
                if (start) begin
                    state_nxt = RUN;
                    cnt_nxt   = '0;
                end
            end
            RUN: begin
                // A start on the final beat chains the next frame with no bubble
                if (last) begin
                    cnt_nxt   = '0;
                    state_nxt = start ? RUN : IDLE;
                end else begin
                    cnt_nxt = cnt + CW'(1);
                end
            end
            default: begin
                state_nxt = IDLE;
                cnt_nxt   = '0;
            end
        endcase
    end

`ifdef FFT_STAGE_ERR_EN
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            err <= 1'b0;
        end else if (active && start && !last) begin
            err <= 1'b1;
        end
    end
`endif

endmodule

// File: rtl/fft_bfly_stage.sv
// Radix-2 butterfly stage over LANES parallel complex lanes, one growth bit.
// Macro FFT_STAGE_ERR_EN exposes the sticky err output of the sequencer.
module fft_bfly_stage
    import fft_pkg::*;
#(
    parameter int WIDTH        = FFT_WIDTH,
    parameter int LANES        = FFT_LANES,
    parameter int PAIR_DIST    = 1,
    parameter int FRAME_CYCLES = FFT_FRAME_CYCLES
) (
    input  logic                    clk,
    input  logic                    rstn,
    input  logic                    start,
    input  logic signed [WIDTH-1:0] din_re  [0:LANES-1],
    input  logic signed [WIDTH-1:0] din_im  [0:LANES-1],
    output logic signed [WIDTH:0]   dout_re [0:LANES-1],
    output logic signed [WIDTH:0]   dout_im [0:LANES-1],
    output logic                    active,
    output logic                    out_valid,
    output logic                    frame_done
`ifdef FFT_STAGE_ERR_EN
    ,
    output logic                    err
`endif
);

    localparam int GROUPS = LANES / (2 * PAIR_DIST);

    logic signed [WIDTH:0] ext_re [0:LANES-1];
    logic signed [WIDTH:0] ext_im [0:LANES-1];
    logic signed [WIDTH:0] nxt_re [0:LANES-1];
    logic signed [WIDTH:0] nxt_im [0:LANES-1];

    fft_frame_cnt #(
        .FRAME_CYCLES(FRAME_CYCLES)
    ) u_cnt (
        .clk       (clk),
        .rstn      (rstn),
        .start     (start),
        .active    (active),
        .frame_done(frame_done)
`ifdef FFT_STAGE_ERR_EN
        ,
        .err       (err)
`endif
    );

    for (genvar k = 0; k < LANES; k++) begin : g_ext
        assign ext_re[k] = (WIDTH + 1)'(din_re[k]);
        assign ext_im[k] = (WIDTH + 1)'(din_im[k]);
    end

    for (genvar g = 0; g < GROUPS; g++) begin : g_grp
        for (genvar j = 0; j < PAIR_DIST; j++) begin : g_pair
            localparam int A = g * 2 * PAIR_DIST + j;
            localparam int B = A + PAIR_DIST;
            assign nxt_re[A] = ext_re[A] + ext_re[B];
            assign nxt_re[B] = ext_re[A] - ext_re[B];
            assign nxt_im[A] = ext_im[A] + ext_im[B];
            assign nxt_im[B] = ext_im[A] - ext_im[B];
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            out_valid <= 1'b0;
            for (int k = 0; k < LANES; k++) begin
                dout_re[k] <= '0;
                dout_im[k] <= '0;
            end
        end else begin
            out_valid <= active;
            if (active) begin
                dout_re <= nxt_re;
                dout_im <= nxt_im;
            end
        end
    end

endmodule

// File: tb/tb_fft_bfly_stage.sv
// Directed bench for fft_bfly_stage (default and PAIR_DIST=4 instances).
// Checks err behaviour when built with FFT_STAGE_ERR_EN.
module tb_fft_bfly_stage;

    logic clk = 1'b0;
    logic rstn = 1'b0;
    logic start = 1'b0;

    logic signed [15:0] din_re [0:15];
    logic signed [15:0] din_im [0:15];
    logic signed [16:0] dout_re [0:15];
    logic signed [16:0] dout_im [0:15];
    logic active, out_valid, frame_done;

    logic signed [15:0] p_re [0:15];
    logic signed [15:0] p_im [0:15];
    logic signed [16:0] q_re [0:15];
    logic signed [16:0] q_im [0:15];
    logic p_active, p_valid, p_done;

`ifdef FFT_STAGE_ERR_EN
    logic err, p_err;
`endif

    int checks = 0;
    int failures = 0;
    int cyc, act_cnt, ov_cnt, fd_cnt, run, max_run;
    int act_first, ov_first, fd_first, fd_last;

    always #5 clk = ~clk;

    fft_bfly_stage u_dut (
        .clk       (clk),
        .rstn      (rstn),
        .start     (start),
        .din_re    (din_re),
        .din_im    (din_im),
        .dout_re   (dout_re),
        .dout_im   (dout_im),
        .active    (active),
        .out_valid (out_valid),
        .frame_done(frame_done)
`ifdef FFT_STAGE_ERR_EN
        ,
        .err       (err)
`endif
    );

    fft_bfly_stage #(
        .PAIR_DIST(4)
    ) u_pd4 (
        .clk       (clk),
        .rstn      (rstn),
        .start     (start),
        .din_re    (p_re),
        .din_im    (p_im),
        .dout_re   (q_re),
        .dout_im   (q_im),
        .active    (p_active),
        .out_valid (p_valid),
        .frame_done(p_done)
`ifdef FFT_STAGE_ERR_EN
        ,
        .err       (p_err)
`endif
    );

    task automatic check(input string tag, input logic signed [63:0] obs,
                         input logic signed [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic clr();
        cyc = 0; act_cnt = 0; ov_cnt = 0; fd_cnt = 0;
        run = 0; max_run = 0;
        act_first = -1; ov_first = -1; fd_first = -1; fd_last = -1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
        if (active) begin
            act_cnt++;
            run++;
            if (run > max_run) max_run = run;
            if (act_first < 0) act_first = cyc;
        end else begin
            run = 0;
        end
        if (out_valid) begin
            ov_cnt++;
            if (ov_first < 0) ov_first = cyc;
        end
        if (frame_done) begin
            fd_cnt++;
            if (fd_first < 0) fd_first = cyc;
            fd_last = cyc;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int k = 0; k < 16; k++) begin
            din_re[k] = '0;
            din_im[k] = '0;
            p_re[k] = 16'(k + 1);
            p_im[k] = 16'(k + 1);
        end
        clr();
        repeat (2) @(posedge clk);
        #1;
        check("rst_active", active, 0);
        check("rst_valid", out_valid, 0);
        check("rst_done", frame_done, 0);
        check("rst_dout_re0", dout_re[0], 0);
        check("rst_dout_im15", dout_im[15], 0);
        rstn = 1'b1;
        tick();

        // Single frame with constant input
        din_re[0] = 100;
        din_re[1] = 30;
        din_im[0] = -5;
        din_im[1] = 7;
        clr();
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (39) tick();
        check("f1_act_cnt", act_cnt, 32);
        check("f1_act_first", act_first, 1);
        check("f1_max_run", max_run, 32);
        check("f1_ov_cnt", ov_cnt, 32);
        check("f1_ov_first", ov_first, 2);
        check("f1_fd_cnt", fd_cnt, 1);
        check("f1_fd_cycle", fd_first, 33);
        check("f1_re0", dout_re[0], 130);
        check("f1_re1", dout_re[1], 70);
        check("f1_im0", dout_im[0], 2);
        check("f1_im1", dout_im[1], -12);
        check("f1_re2", dout_re[2], 0);
        check("pd4_0", q_re[0], 6);
        check("pd4_4", q_re[4], -4);
        check("pd4_8", q_re[8], 22);
        check("pd4_12", q_im[12], -4);
        check("pd4_1", q_re[1], 8);

        // Output holds while idle
        din_re[0] = 5;
        tick();
        check("hold_re0", dout_re[0], 130);
        check("hold_valid", out_valid, 0);

        // Extremes
        clr();
        start = 1'b1;
        tick();
        start = 1'b0;
        din_re[0] = -32768;
        din_re[1] = -32768;
        tick();
        check("ext_sum_min", dout_re[0], -65536);
        check("ext_diff_zero", dout_re[1], 0);
        din_re[1] = 32767;
        tick();
        check("ext_diff_min", dout_re[1], -65535);
        check("ext_sum_m1", dout_re[0], -1);
        repeat (40) tick();

        // Back-to-back frames
        clr();
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (31) tick();
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (40) tick();
        check("b2b_act_cnt", act_cnt, 64);
        check("b2b_max_run", max_run, 64);
        check("b2b_ov_cnt", ov_cnt, 64);
        check("b2b_fd_cnt", fd_cnt, 2);
        check("b2b_fd_first", fd_first, 33);
        check("b2b_fd_gap", fd_last - fd_first, 32);

        // Start mid-frame is ignored
        clr();
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (10) tick();
        start = 1'b1;
        tick();
        start = 1'b0;
`ifdef FFT_STAGE_ERR_EN
        check("ign_err_set", err, 1);
`endif
        repeat (40) tick();
        check("ign_act_cnt", act_cnt, 32);
        check("ign_max_run", max_run, 32);
        check("ign_fd_cnt", fd_cnt, 1);
        check("ign_fd_cycle", fd_first, 33);
`ifdef FFT_STAGE_ERR_EN
        check("ign_err_sticky", err, 1);
`endif

        // Reset mid-frame
        clr();
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (15) tick();
        check("mid_active", active, 1);
        rstn = 1'b0;
        #1;
        check("mrst_active", active, 0);
        check("mrst_valid", out_valid, 0);
        check("mrst_done", frame_done, 0);
        check("mrst_re0", dout_re[0], 0);
        check("mrst_im1", dout_im[1], 0);
`ifdef FFT_STAGE_ERR_EN
        check("mrst_err", err, 0);
`endif
        repeat (3) tick();
        rstn = 1'b1;
        repeat (20) tick();
        check("mrst_no_fd", fd_cnt, 0);
        clr();
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (40) tick();
        check("post_act_cnt", act_cnt, 32);
        check("post_ov_cnt", ov_cnt, 32);
        check("post_fd_cnt", fd_cnt, 1);
        check("post_fd_cycle", fd_first, 33);
        check("post_re0", dout_re[0], -1);
        check("post_re1", dout_re[1], -65535);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
